// File: rtl/red_pkg.sv
// Shared constants and types for the reduced RISC-V fetch/decode front end.
package red_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam logic [6:0] F7_ADD    = 7'h00;
    localparam logic [6:0] F7_SUB    = 7'h20;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

endpackage

// File: rtl/red_fetch_decode_if.sv
// Instruction-memory req/ack port. The fetch unit is the master.
interface red_fetch_decode_if #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/red_imm_gen.sv
// Immediate generator: sign-extends the I-format (OP_IMM) or B-format
// (OP_BRANCH) immediate from the instruction word; zero for other opcodes.
module red_imm_gen
    import red_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [11:0] i_imm;
    logic [12:0] b_imm;

    assign i_imm = ir[31:20];
    assign b_imm = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    // Pick the immediate format from the opcode
    always_comb begin
        imm = '0;
        case (ir[6:0])
            OP_IMM:    imm = DATA_WIDTH'($signed(i_imm));
            OP_BRANCH: imm = DATA_WIDTH'($signed(b_imm));
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/red_fetch_decode.sv
// Fetch/decode control front end: FSM, PC and IR registers, decode, branch adder.
// Optional build macro RED_ILLEGAL_TRAP_EN: an illegal instruction halts the
// core (HALT state) instead of being skipped as a NOP.
module red_fetch_decode
    import red_pkg::*;
#(
    parameter int                PC_WIDTH      = 32,
    parameter int                DATA_WIDTH    = 32,
    parameter int                ADDRESS_WIDTH = 5,
    parameter int                ALUctrl_WIDTH = 3,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    red_fetch_decode_if.master       imem,
    input  logic                     EQ,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic [ALUctrl_WIDTH-1:0] ALUctrl,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     illegal
);

    state_t                state, state_nxt;
    logic [PC_WIDTH-1:0]   pc, pc_nxt;
    logic [DATA_WIDTH-1:0] ir, imm;
    logic                  req;

    logic [6:0] op, f7;
    logic [2:0] f3, alu_sel;
    logic       legal, reg_wr, alu_src, use_imm, is_br, br_ne, taken;

    assign op = ir[6:0];
    assign f3 = ir[14:12];
    assign f7 = ir[31:25];

    red_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm (.ir(ir), .imm(imm));

    // Instruction decode; anything not matched is illegal with all controls low
    always_comb begin
        legal   = 1'b0;
        reg_wr  = 1'b0;
        alu_src = 1'b0;
        alu_sel = ALU_ADD;
        use_imm = 1'b0;
        is_br   = 1'b0;
        br_ne   = 1'b0;
        case (op)
            OP_IMM: if (f3 == F3_ADD) begin
                legal   = 1'b1;
                reg_wr  = 1'b1;
                alu_src = 1'b1;
                use_imm = 1'b1;
            end
            OP_REG: if (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) begin
                legal   = 1'b1;
                reg_wr  = 1'b1;
                alu_sel = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
            end
            OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) begin
                legal   = 1'b1;
                is_br   = 1'b1;
                br_ne   = (f3 == F3_BNE);
                alu_sel = ALU_SUB;
                use_imm = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch resolution against the datapath EQ flag; PC wraps silently
    assign taken  = is_br & (br_ne ? ~EQ : EQ);
    assign pc_nxt = taken ? pc + PC_WIDTH'(imm) : pc + PC_WIDTH'(4);

    // Next-state and fetch request
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                req = 1'b1;
                if (imem.imem_ack) state_nxt = EXEC;
            end
`ifdef RED_ILLEGAL_TRAP_EN
            EXEC:  state_nxt = legal ? FETCH : HALT;
`else
            EXEC:  state_nxt = FETCH;
`endif
            HALT:  state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // PC, IR and sticky illegal flag; PC holds when trapping into HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            if (state == FETCH && imem.imem_ack) ir <= imem.imem_rdata;
            if (state == EXEC && state_nxt == FETCH) pc <= pc_nxt;
            if (state == EXEC && !legal) illegal <= 1'b1;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign rd       = ir[11:7];
    assign RegWrite = reg_wr && (state == EXEC);
    assign ALUsrc   = alu_src;
    assign ALUctrl  = ALUctrl_WIDTH'(alu_sel);
    assign ImmOp    = use_imm ? imm : '0;

endmodule
